// File: rtl/instruction_fetcher_pkg.sv
// Shared types and helpers for the instruction fetcher: FSM encoding, queue entry
// layout and the static next-PC predictor.
package instruction_fetcher_pkg;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pred;
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Only JAL is redirected statically; branches and JALR fall through and the ROB repairs them.
    function automatic logic [31:0] predict_npc(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        if (inst[6:0] == OPC_JAL) begin
            return pc + imm;
        end
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bus bundles of the instruction fetcher: the request/return link to the memory
// controller and the pop port towards the decoder.
interface instruction_fetcher_mem_if;
    logic        fetch_start;
    logic [31:0] pc;
    logic        finish_fetch;
    logic [31:0] inst_in;
    logic [31:0] inst_pc_in;

    modport master (output fetch_start, pc, input finish_fetch, inst_in, inst_pc_in);
    modport slave  (input fetch_start, pc, output finish_fetch, inst_in, inst_pc_in);
endinterface

interface instruction_fetcher_iq_if;
    logic        iq_pop;
    logic        iq_valid;
    logic        iq_full;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic [31:0] inst_pred_pc;

    modport master (input iq_pop, output iq_valid, iq_full, inst_out, inst_pc_out, inst_pred_pc);
    modport slave  (output iq_pop, input iq_valid, iq_full, inst_out, inst_pc_out, inst_pred_pc);
endinterface

// File: rtl/instruction_fetcher_inst_queue.sv
// Synchronous FIFO of fetched instructions {pred, pc, inst}; flush clears the pointers,
// and the head output reads as zero whenever the queue is empty.
module inst_queue
    import instruction_fetcher_pkg::*;
#(
    parameter int IQ_DEPTH_LOG = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush,
    input  logic                  push,
    input  iq_entry_t             push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic                  full,
    output logic [IQ_DEPTH_LOG:0] count,
    output iq_entry_t             head_data
);
    localparam int CW    = IQ_DEPTH_LOG + 1;
    localparam int DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [CW-1:0]           DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW-1:0]           CNT_ONE = 1;
    localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE = 1;

    iq_entry_t mem_q [DEPTH];

    logic [IQ_DEPTH_LOG-1:0] head_q, head_d;
    logic [IQ_DEPTH_LOG-1:0] tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    push_eff, pop_eff;

    assign valid   = (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign pop_eff = pop && valid && !flush;
    // A full queue can still take a word when the head leaves in the same cycle.
    assign push_eff = push && !flush && (!full || pop_eff);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_eff) tail_d = tail_q + PTR_ONE;
            if (pop_eff)  head_d = head_q + PTR_ONE;
            case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_eff) mem_q[tail_q] <= push_data;
    end

    assign head_data = valid ? mem_q[head_q] : '0;

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: keeps one fetch outstanding towards the memory controller, predicts
// the next PC statically and buffers returned words for the decoder.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH_LOG = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] roll_back_pc,
    instruction_fetcher_mem_if.master fetch_bus,
    instruction_fetcher_iq_if.master  queue_bus
);
    localparam int CW    = IQ_DEPTH_LOG + 1;
    localparam int DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE = 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fetch_start_q, fetch_start_d;

    logic          push_req, pop_req, flush_req;
    logic          q_valid, q_full;
    logic [CW-1:0] q_count, count_after;
    logic          has_room, room_after;
    logic [31:0]   npc;
    iq_entry_t     push_data, head_data;

    assign npc       = predict_npc(pc_q, fetch_bus.inst_in);
    assign push_data = '{pred: npc, pc: fetch_bus.inst_pc_in, inst: fetch_bus.inst_in};

    // Occupancy once the word returning this cycle lands; WAIT implies a free slot was reserved.
    assign count_after = (queue_bus.iq_pop && q_valid) ? q_count : q_count + CNT_ONE;
    assign has_room    = (q_count < DEPTH_C);
    assign room_after  = (count_after < DEPTH_C);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            fetch_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_start_q <= fetch_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (roll_back) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:  if (has_room) state_d = S_WAIT;
                    S_WAIT:  if (fetch_bus.finish_fetch && !room_after) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        fetch_start_d = fetch_start_q;
        pc_d          = pc_q;
        push_req      = 1'b0;
        pop_req       = 1'b0;
        flush_req     = 1'b0;
        if (rdy_in) begin
            if (roll_back) begin
                flush_req     = 1'b1;
                pc_d          = roll_back_pc;
                fetch_start_d = 1'b0;
            end else begin
                pop_req = queue_bus.iq_pop;
                case (state_q)
                    S_IDLE: fetch_start_d = has_room;
                    S_WAIT: begin
                        // pc moves on the sampling edge so the icache fill still sees the old address.
                        if (fetch_bus.finish_fetch) begin
                            push_req      = 1'b1;
                            pc_d          = npc;
                            fetch_start_d = room_after;
                        end
                    end
                    default: fetch_start_d = 1'b0;
                endcase
            end
        end
    end

    inst_queue #(
        .IQ_DEPTH_LOG(IQ_DEPTH_LOG)
    ) u_inst_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (flush_req),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop_req),
        .valid     (q_valid),
        .full      (q_full),
        .count     (q_count),
        .head_data (head_data)
    );

    assign fetch_bus.fetch_start  = fetch_start_q;
    assign fetch_bus.pc           = pc_q;
    assign queue_bus.iq_valid     = q_valid;
    assign queue_bus.iq_full      = q_full;
    assign queue_bus.inst_out     = head_data.inst;
    assign queue_bus.inst_pc_out  = head_data.pc;
    assign queue_bus.inst_pred_pc = head_data.pred;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: stimulus pushes expected queue entries into a
// scoreboard that a negedge monitor drains whenever the decoder side pops a valid head.
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic [31:0] roll_back_pc;

    instruction_fetcher_mem_if mem_bus ();
    instruction_fetcher_iq_if  iq_bus ();

    instruction_fetcher #(
        .IQ_DEPTH_LOG(4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .roll_back    (roll_back),
        .roll_back_pc (roll_back_pc),
        .fetch_bus    (mem_bus.master),
        .queue_bus    (iq_bus.master)
    );

    always #5 clk_in = ~clk_in;

    int        vectors = 0;
    int        miscompares = 0;
    iq_entry_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic deliver(input logic [31:0] ins, input logic [31:0] ipc,
                           input logic [31:0] pred, input bit expect_push);
        iq_entry_t e;
        mem_bus.finish_fetch = 1'b1;
        mem_bus.inst_in      = ins;
        mem_bus.inst_pc_in   = ipc;
        if (expect_push) begin
            e.pred = pred;
            e.pc   = ipc;
            e.inst = ins;
            exp_q.push_back(e);
        end
        step();
        mem_bus.finish_fetch = 1'b0;
    endtask

    task automatic pop_n(input int n);
        iq_bus.iq_pop = 1'b1;
        for (int k = 0; k < n; k++) step();
        iq_bus.iq_pop = 1'b0;
    endtask

    // Scoreboard monitor: compares the head at every accepted pop.
    always @(negedge clk_in) begin
        iq_entry_t e;
        if (!rst_in && rdy_in && !roll_back && iq_bus.iq_pop && iq_bus.iq_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected_pop: got pc 0x%08h, expected no entry", iq_bus.inst_pc_out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", iq_bus.inst_out, e.inst);
                chk("sb_pc", iq_bus.inst_pc_out, e.pc);
                chk("sb_pred", iq_bus.inst_pred_pc, e.pred);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] p;
        rst_in               = 1'b1;
        rdy_in               = 1'b1;
        roll_back            = 1'b0;
        roll_back_pc         = 32'h0;
        mem_bus.finish_fetch = 1'b0;
        mem_bus.inst_in      = 32'h0;
        mem_bus.inst_pc_in   = 32'h0;
        iq_bus.iq_pop        = 1'b0;
        step();
        step();

        // 1: reset values, then the first request
        chk("rst_fetch_start", 32'(mem_bus.fetch_start), 32'h0);
        chk("rst_pc", mem_bus.pc, 32'h0);
        chk("rst_iq_valid", 32'(iq_bus.iq_valid), 32'h0);
        chk("rst_iq_full", 32'(iq_bus.iq_full), 32'h0);
        chk("rst_inst_out", iq_bus.inst_out, 32'h0);
        rst_in = 1'b0;
        chk("rel_fetch_start_c0", 32'(mem_bus.fetch_start), 32'h0);
        step();
        chk("rel_fetch_start_c1", 32'(mem_bus.fetch_start), 32'h1);
        chk("rel_pc_c1", mem_bus.pc, 32'h0);
        chk("rel_iq_valid_c1", 32'(iq_bus.iq_valid), 32'h0);

        // 2: first word, fall-through prediction
        deliver(32'h0000_0013, 32'h0, 32'h4, 1'b1);
        chk("t2_iq_valid", 32'(iq_bus.iq_valid), 32'h1);
        chk("t2_inst_out", iq_bus.inst_out, 32'h13);
        chk("t2_pred", iq_bus.inst_pred_pc, 32'h4);
        chk("t2_pc", mem_bus.pc, 32'h4);
        chk("t2_fetch_start", 32'(mem_bus.fetch_start), 32'h1);
        pop_n(1);
        chk("t2_drained", 32'(iq_bus.iq_valid), 32'h0);

        // 3: JAL prediction at pc 0x10
        deliver(32'h0000_0013, 32'h4, 32'h8, 1'b1);
        deliver(32'h0000_0013, 32'h8, 32'hC, 1'b1);
        deliver(32'h0000_0013, 32'hC, 32'h10, 1'b1);
        chk("t3_pc_before_jal", mem_bus.pc, 32'h10);
        deliver(32'h0080_006F, 32'h10, 32'h18, 1'b1);
        chk("t3_pc_after_jal", mem_bus.pc, 32'h18);
        pop_n(4);
        chk("t3_drained", 32'(iq_bus.iq_valid), 32'h0);

        // 4: fill the queue, stall, free a slot and resume
        p = 32'h18;
        for (int i = 0; i < 16; i++) begin
            deliver(32'h0000_0013, p, p + 32'd4, 1'b1);
            p = p + 32'd4;
        end
        chk("t4_full", 32'(iq_bus.iq_full), 32'h1);
        chk("t4_fetch_stop", 32'(mem_bus.fetch_start), 32'h0);
        chk("t4_pc", mem_bus.pc, 32'h58);
        step();
        chk("t4_fetch_still_stop", 32'(mem_bus.fetch_start), 32'h0);
        pop_n(1);
        chk("t4_not_full", 32'(iq_bus.iq_full), 32'h0);
        step();
        chk("t4_fetch_resume", 32'(mem_bus.fetch_start), 32'h1);
        deliver(32'h0000_0013, 32'h58, 32'h5C, 1'b1);
        chk("t4_full_again", 32'(iq_bus.iq_full), 32'h1);
        chk("t4_fetch_stop_again", 32'(mem_bus.fetch_start), 32'h0);
        pop_n(16);
        chk("t4_drained", 32'(iq_bus.iq_valid), 32'h0);
        chk("t4_fetch_after_drain", 32'(mem_bus.fetch_start), 32'h1);
        chk("t4_pc_after_drain", mem_bus.pc, 32'h5C);

        // 5: roll_back coinciding with finish_fetch drops the word and the queue
        deliver(32'h0000_0013, 32'h5C, 32'h60, 1'b1);
        chk("t5_queued", 32'(iq_bus.iq_valid), 32'h1);
        exp_q.delete();
        roll_back    = 1'b1;
        roll_back_pc = 32'h100;
        deliver(32'h0000_0013, 32'h60, 32'h64, 1'b0);
        roll_back = 1'b0;
        chk("t5_iq_valid", 32'(iq_bus.iq_valid), 32'h0);
        chk("t5_fetch_start_c1", 32'(mem_bus.fetch_start), 32'h0);
        chk("t5_pc_c1", mem_bus.pc, 32'h100);
        step();
        chk("t5_fetch_start_c2", 32'(mem_bus.fetch_start), 32'h1);
        chk("t5_pc_c2", mem_bus.pc, 32'h100);
        pop_n(1);
        chk("t5_pop_empty", 32'(iq_bus.iq_valid), 32'h0);

        // 6: pause holds everything, then asynchronous reset
        deliver(32'h0000_0013, 32'h100, 32'h104, 1'b1);
        rdy_in               = 1'b0;
        mem_bus.finish_fetch = 1'b1;
        mem_bus.inst_in      = 32'h0000_0013;
        mem_bus.inst_pc_in   = 32'h104;
        iq_bus.iq_pop        = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rdy_in               = 1'b1;
        mem_bus.finish_fetch = 1'b0;
        iq_bus.iq_pop        = 1'b0;
        chk("t6_pc_held", mem_bus.pc, 32'h104);
        chk("t6_fetch_held", 32'(mem_bus.fetch_start), 32'h1);
        chk("t6_iq_valid_held", 32'(iq_bus.iq_valid), 32'h1);
        chk("t6_head_pc_held", iq_bus.inst_pc_out, 32'h100);
        chk("t6_head_pred_held", iq_bus.inst_pred_pc, 32'h104);
        #2;
        rst_in = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_arst_fetch_start", 32'(mem_bus.fetch_start), 32'h0);
        chk("t6_arst_pc", mem_bus.pc, 32'h0);
        chk("t6_arst_iq_valid", 32'(iq_bus.iq_valid), 32'h0);
        chk("t6_arst_inst_out", iq_bus.inst_out, 32'h0);
        chk("t6_arst_inst_pc", iq_bus.inst_pc_out, 32'h0);
        chk("t6_arst_pred", iq_bus.inst_pred_pc, 32'h0);
        step();
        rst_in = 1'b0;
        step();
        chk("t6_restart_fetch", 32'(mem_bus.fetch_start), 32'h1);
        chk("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
